// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMEM write/status bus of the boot loader.
// The loader uses the slave modport; the stream source uses master.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a framed little-endian word image into IMEM from a byte stream and
// holds the CPU in reset until the whole image has arrived with a good checksum.
module imem_boot_loader #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [7:0]        xor_q, xor_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic             receiving;
  logic             accept;
  logic [7:0]       xor_nx;
  logic [CNT_W-1:0] cnt_full;

  assign receiving = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = bus.in_valid && bus.in_ready;
  assign xor_nx    = xor_q ^ bus.in_data;
  assign cnt_full  = {bus.in_data, cnt_q[7:0]};

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      bidx_q  <= '0;
      xor_q   <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      bidx_q  <= bidx_d;
      xor_q   <= xor_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and next-register values; a cycle without accept holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    bidx_d  = bidx_q;
    xor_d   = xor_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          cnt_d   = {cnt_q[15:8], bus.in_data};
          xor_d   = xor_nx;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          cnt_d = cnt_full;
          xor_d = xor_nx;
          if ((cnt_full == '0) || (cnt_full > DEPTH_CNT)) state_d = S_ERROR;
          else                                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d  = xor_nx;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: wbuf_d[7:0]   = bus.in_data;
            2'd1: wbuf_d[15:8]  = bus.in_data;
            2'd2: wbuf_d[23:16] = bus.in_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = wcnt_q[ADDR_W-1:0];
              wdata_d = {bus.in_data, wbuf_q};
              wcnt_d  = wcnt_q + CNT_W'(1);
              if ((wcnt_q + CNT_W'(1)) == cnt_q) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          xor_d = xor_nx;
          if (xor_nx == 8'h00) state_d = S_DONE;
          else                 state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // in_ready follows the state but is forced low while reset is held.
  assign bus.in_ready   = receiving && !rst;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_rst    = (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_ERROR);

endmodule
